// File: rtl/btn_cmd_if.sv
// btn_cmd_if: button/switch inputs and LED/command status bundle
// for btn_cmd_arbiter.
interface btn_cmd_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       btns;
  logic [CNT_W-1:0] sw;
  logic [CNT_W-1:0] leds;
  logic [3:0]       pending;
  logic [3:0]       grant;
  logic             busy;

  modport master (
    output btns, sw,
    input  leds, pending, grant, busy
  );

  modport slave (
    input  btns, sw,
    output leds, pending, grant, busy
  );
endinterface

// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: debounced 4-button round-robin command unit on a shared
// LED counter. Define BTN_CMD_SATURATE_EN to saturate inc/dec instead of wrap.
module btn_cmd_arbiter #(
  parameter int DEBOUNCE_W = 8,
  parameter int CNT_W      = 4,
  parameter int HOLDOFF    = 4
) (
  input  logic     CLK_IN,
  input  logic     CPU_RESETN,
  btn_cmd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_e;

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HLAST =
    HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic [3:0][2:0]            sync_q, sync_d;
  logic [3:0][DEBOUNCE_W-1:0] dcnt_q, dcnt_d;
  logic [3:0]                 arm_q, arm_d;
  logic [3:0]                 evt;
  logic [CNT_W-1:0]           sw0_q, sw1_q;
  logic [3:0]                 pend_q, pend_d;
  logic [3:0]                 grant_q, grant_d;
  logic [3:0]                 clr;
  logic [1:0]                 gidx_q, gidx_d;
  logic [1:0]                 ptr_q, ptr_d;
  logic [CNT_W-1:0]           leds_q, leds_d;
  logic [HW-1:0]              hcnt_q, hcnt_d;
  state_e                     state_q, state_d;
  logic                       found;
  logic [1:0]                 sel;

  // Rising edge of sync[2:1] arms; counter runs while sync[1] stays high.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sync_d[i] = {sync_q[i][1:0], bus.btns[i]};
      arm_d[i]  = arm_q[i];
      dcnt_d[i] = dcnt_q[i];
      evt[i]    = 1'b0;
      if (sync_q[i][2:1] == 2'b01) begin
        arm_d[i]  = 1'b1;
        dcnt_d[i] = '0;
      end else if (arm_q[i]) begin
        if (!sync_q[i][1]) begin
          arm_d[i]  = 1'b0;
          dcnt_d[i] = '0;
        end else if (&dcnt_q[i]) begin
          evt[i]    = 1'b1;
          arm_d[i]  = 1'b0;
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(k);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    gidx_d  = gidx_q;
    hcnt_d  = hcnt_q;
    ptr_d   = ptr_q;
    leds_d  = leds_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'(1) << sel;
          gidx_d  = sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        clr     = grant_q;
        ptr_d   = gidx_q + 2'd1;
        hcnt_d  = '0;
        state_d = (HOLDOFF > 0) ? HOLD : IDLE;
        unique case (1'b1)
`ifdef BTN_CMD_SATURATE_EN
          grant_q[0]: leds_d = (&leds_q) ? leds_q
                             : leds_q + CNT_W'(1);
          grant_q[1]: leds_d = (leds_q == '0) ? leds_q
                             : leds_q - CNT_W'(1);
`else
          grant_q[0]: leds_d = leds_q + CNT_W'(1);
          grant_q[1]: leds_d = leds_q - CNT_W'(1);
`endif
          grant_q[2]: leds_d = '0;
          grant_q[3]: leds_d = sw1_q;
          default:    leds_d = leds_q;
        endcase
      end
      HOLD: begin
        if (hcnt_q == HLAST) begin
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle debounce event wins over the grant clear.
  assign pend_d = (pend_q & ~clr) | evt;

  always_ff @(posedge CLK_IN) begin
    if (!CPU_RESETN) begin
      sync_q  <= '0;
      dcnt_q  <= '0;
      arm_q   <= '0;
      sw0_q   <= '0;
      sw1_q   <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      leds_q  <= '0;
      hcnt_q  <= '0;
      state_q <= IDLE;
    end else begin
      sync_q  <= sync_d;
      dcnt_q  <= dcnt_d;
      arm_q   <= arm_d;
      sw0_q   <= bus.sw;
      sw1_q   <= sw0_q;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      leds_q  <= leds_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
    end
  end

  assign bus.leds    = leds_q;
  assign bus.pending = pend_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// tb_btn_cmd_arbiter: scoreboard bench for btn_cmd_arbiter
// (DEBOUNCE_W=2, CNT_W=4, HOLDOFF=4).
module tb_btn_cmd_arbiter;

  typedef struct {
    logic [3:0] g;
    logic [3:0] l;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t       sb[$];
  logic [3:0] model_leds = '0;
  bit         mon_en     = 1'b0;
  bit         chk_leds   = 1'b0;
  logic [3:0] exp_leds   = '0;
  logic [3:0] prev_leds  = '0;

  btn_cmd_if #(.CNT_W(4)) bus ();

  btn_cmd_arbiter #(
    .DEBOUNCE_W(2),
    .CNT_W     (4),
    .HOLDOFF   (4)
  ) dut (
    .CLK_IN    (clk),
    .CPU_RESETN(rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] op_res(int idx, logic [3:0] cur,
                                        logic [3:0] s);
    case (idx)
`ifdef BTN_CMD_SATURATE_EN
      0: return (cur == 4'hF) ? cur : cur + 4'd1;
      1: return (cur == 4'h0) ? cur : cur - 4'd1;
`else
      0: return cur + 4'd1;
      1: return cur - 4'd1;
`endif
      2: return 4'h0;
      default: return s;
    endcase
  endfunction

  task automatic push(int idx);
    exp_t e;
    model_leds = op_res(idx, model_leds, bus.sw);
    e.g = 4'(1) << idx;
    e.l = model_leds;
    sb.push_back(e);
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0 && !chk_leds) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  // Scoreboard consumer: every grant pulse pops one expected command.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_leds) begin
        checks++;
        if (bus.leds !== exp_leds) begin
          errors++;
          $display("FAIL leds_after_grant: got %h want %h",
                   bus.leds, exp_leds);
        end
        chk_leds = 1'b0;
      end else if (bus.leds !== prev_leds) begin
        checks++;
        errors++;
        $display("FAIL leds_no_grant: got %h want %h",
                 bus.leds, prev_leds);
      end
      if (bus.grant !== 4'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got %b want none",
                   bus.grant);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.grant !== e.g) begin
            errors++;
            $display("FAIL grant_order: got %b want %b",
                     bus.grant, e.g);
          end
          exp_leds = e.l;
          chk_leds = 1'b1;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_grant: got %b want 1", bus.busy);
        end
      end
      prev_leds = bus.leds;
    end
  end

  task automatic test_reset;
    int edges;
    bit ok;
    mon_en   = 1'b0;
    bus.btns = 4'hF;
    bus.sw   = 4'h5;
    rstn     = 1'b0;
    cyc(5);
    checks++;
    if (bus.leds !== 4'h0) begin
      errors++;
      $display("FAIL rst_leds: got %h want 0", bus.leds);
    end
    checks++;
    if (bus.pending !== 4'h0) begin
      errors++;
      $display("FAIL rst_pending: got %h want 0", bus.pending);
    end
    checks++;
    if (bus.grant !== 4'h0) begin
      errors++;
      $display("FAIL rst_grant: got %h want 0", bus.grant);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
    sb.delete();
    model_leds = 4'h0;
    for (int i = 0; i < 4; i++) push(i);
    chk_leds  = 1'b0;
    prev_leds = bus.leds;
    rstn      = 1'b1;
    mon_en    = 1'b1;
    edges     = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      edges++;
      if (bus.pending !== 4'h0) break;
    end
    checks++;
    if (edges !== 7) begin
      errors++;
      $display("FAIL rst_debounce_edges: got %0d want 7", edges);
    end
    checks++;
    if (bus.pending !== 4'hF) begin
      errors++;
      $display("FAIL rst_pending_all: got %h want f", bus.pending);
    end
    bus.btns = 4'h0;
    wait_drain(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_drain: got timeout want drained");
    end
  endtask

  task automatic test_single_press;
    int edges;
    bit ok;
    bus.btns = 4'b0001;
    push(0);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      edges++;
      if (bus.pending[0] === 1'b1) break;
    end
    checks++;
    if (edges !== 7) begin
      errors++;
      $display("FAIL single_edges: got %0d want 7", edges);
    end
    cyc(20 - edges);
    bus.btns = 4'b0;
    wait_drain(100, ok);
    cyc(10);
    checks++;
    if (!ok || bus.leds !== model_leds) begin
      errors++;
      $display("FAIL single_leds: got %h want %h", bus.leds, model_leds);
    end
    checks++;
    if (bus.pending !== 4'h0) begin
      errors++;
      $display("FAIL single_pending_clr: got %h want 0", bus.pending);
    end
  endtask

  task automatic test_glitch;
    bit seen;
    bus.btns = 4'b0010;
    cyc(3);
    bus.btns = 4'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.pending !== 4'h0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL glitch_pending: got set want 0");
    end
    checks++;
    if (bus.leds !== model_leds) begin
      errors++;
      $display("FAIL glitch_leds: got %h want %h", bus.leds, model_leds);
    end
  endtask

  task automatic test_contention;
    int t[4];
    int n;
    bit ok;
    bus.sw   = 4'h3;
    bus.btns = 4'b1000;
    push(3);
    cyc(10);
    bus.btns = 4'b0;
    wait_drain(100, ok);
    checks++;
    if (!ok || bus.leds !== 4'h3) begin
      errors++;
      $display("FAIL cont_load3: got %h want 3", bus.leds);
    end
    bus.sw = 4'hA;
    cyc(4);
    bus.btns = 4'hF;
    for (int i = 0; i < 4; i++) push(i);
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      cyc(1);
      if (i == 10) bus.btns = 4'b0;
      if (bus.grant !== 4'b0) begin
        t[n] = i;
        n++;
      end
    end
    bus.btns = 4'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL cont_count: got %0d want 4", n);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (t[k+1] - t[k] !== 6) begin
          errors++;
          $display("FAIL cont_spacing%0d: got %0d want 6",
                   k, t[k+1] - t[k]);
        end
      end
    end
    wait_drain(100, ok);
    checks++;
    if (!ok || bus.leds !== 4'hA) begin
      errors++;
      $display("FAIL cont_final: got %h want a", bus.leds);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    bit seen;
    bus.btns = 4'b0100;
    push(2);
    cyc(10);
    bus.btns = 4'b0;
    wait_drain(100, ok);
    checks++;
    if (!ok || bus.leds !== 4'h0) begin
      errors++;
      $display("FAIL wrap_clear: got %h want 0", bus.leds);
    end
    bus.btns = 4'b0010;
    push(1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bus.grant === 4'b0010) seen = 1'b1;
    end
    bus.btns = 4'b0;
    wait_drain(100, ok);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wrap_grant: got none want 0010");
    end
    checks++;
    if (!ok || bus.leds !== model_leds) begin
      errors++;
      $display("FAIL wrap_leds: got %h want %h", bus.leds, model_leds);
    end
  endtask

  task automatic test_reset_midop;
    bit ok;
    bit hit;
    bus.btns = 4'b0001;
    push(0);
    cyc(10);
    bus.btns = 4'b0;
    wait_drain(100, ok);
    bus.btns = 4'b0110;
    push(1);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (bus.grant === 4'b0010) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midop_grant1: got none want 0010");
    end
    cyc(2);
    checks++;
    if (bus.busy !== 1'b1 || bus.pending !== 4'b0100) begin
      errors++;
      $display("FAIL midop_hold: got busy=%b pend=%b want 1 0100",
               bus.busy, bus.pending);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL midop_sb: got %0d left want 0", sb.size());
    end
    mon_en   = 1'b0;
    bus.btns = 4'b0;
    rstn     = 1'b0;
    cyc(1);
    checks++;
    if (bus.pending !== 4'h0 || bus.leds !== 4'h0) begin
      errors++;
      $display("FAIL midop_rst: got pend=%h leds=%h want 0 0",
               bus.pending, bus.leds);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'h0) begin
      errors++;
      $display("FAIL midop_idle: got busy=%b grant=%h want 0 0",
               bus.busy, bus.grant);
    end
    sb.delete();
    model_leds = 4'h0;
    chk_leds   = 1'b0;
    rstn       = 1'b1;
    prev_leds  = bus.leds;
    mon_en     = 1'b1;
    cyc(20);
    checks++;
    if (bus.pending !== 4'h0 || bus.leds !== 4'h0) begin
      errors++;
      $display("FAIL midop_after: got pend=%h leds=%h want 0 0",
               bus.pending, bus.leds);
    end
  endtask

  initial begin
    bus.btns = 4'b0;
    bus.sw   = 4'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_contention();
    test_wrap();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_cmd_arbiter.md
Name: btn_cmd_arbiter

Overview:
- Four-button command controller for the PL-only LED designs.
- Each raw button is synchronised and debounced, and a qualified press is latched as a pending command.
- A round-robin scheduler grants pending commands one at a time to a shared CNT_W-bit counter that drives the LEDs.
- Per-button ops: btns[0] increment, btns[1] decrement, btns[2] clear, btns[3] load from switches.

Parameters:
- DEBOUNCE_W, 8, debounce counter width; a press must stay high for 2^DEBOUNCE_W cycles after detection.
- CNT_W, 4, width of the shared counter, sw and leds.
- HOLDOFF, 4, idle cycles inserted after each grant (0 allowed).

Ports:
- CLK_IN  in  1  single system clock; all logic on posedge.
- CPU_RESETN  in  1  reset, synchronous, active-low.
- btns  in  4  raw asynchronous push buttons, active-high.
- sw  in  CNT_W  raw switches; load value for btns[3].
- leds  out  CNT_W  shared counter value.
- pending  out  4  latched, not-yet-granted commands.
- grant  out  4  one-hot pulse, high for the single cycle a command executes.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset: CPU_RESETN=0 at a clock edge clears everything.
  - Syncs, debounce counters, arm flags and pending → 0.
  - leds → 0, grant → 0, busy → 0, state → IDLE, RR pointer → 0.
  - Reset dominates every other event, including mid-debounce and mid-HOLDOFF.
- Per-channel synchroniser: 3-flop shift register sync[2:0] with sync[0]←btn. sw uses a 2-flop sync per bit.
- Per-channel debounce:
  - sync[2:1]==2'b01 arms the channel and clears its counter.
  - While armed and sync[1]==1, the counter increments each cycle.
  - sync[1]==0 while armed → disarm, counter cleared, no event.
  - Counter all-ones while armed → pending[i]←1, disarm, counter cleared.
  - Held press: pending rises exactly 2^DEBOUNCE_W+3 edges after the first edge sampling btn high (DEBOUNCE_W=2 → 7 edges).
  - One event per press; holding the button never repeats.
- Pending:
  - A new event on a channel that is already pending coalesces; there is no queue.
  - Grant clears that channel's bit. If a new event arrives in the same cycle as its grant, set wins and the bit stays 1.
- FSM:
  - IDLE: if pending!=0, pick the first pending index at or after the RR pointer (wrapping 3→0), register a one-hot grant, go GRANT. Otherwise stay.
  - GRANT (1 cycle): grant asserted, op applied to leds at the end of the cycle, pending bit cleared, pointer←(i+1) mod 4. Go HOLDOFF if HOLDOFF>0, else IDLE.
  - HOLDOFF: count HOLDOFF cycles, then IDLE.
  - Consecutive grant spacing: HOLDOFF+2 cycles.
- Ops on leds:
  - inc: wraps 2^CNT_W−1→0.
  - dec: wraps 0→2^CNT_W−1.
  - clear: →0.
  - load: takes the synchronised sw value in the GRANT cycle.
- leds changes only in a GRANT cycle. grant==0 outside GRANT. busy is high in GRANT and HOLDOFF.

Optional Feature:
- Macro: BTN_CMD_SATURATE_EN.
- Defined: inc holds at 2^CNT_W−1 and dec holds at 0. The grant pulse and pending clear still occur.
- Undefined: inc and dec wrap as described above.

Test Plan:
- Reset: CPU_RESETN=0 for 5 cycles with btns=4'hF → leds=0, pending=0, grant=0, busy=0. After release, pending follows the debounce timing.
- Single press (DEBOUNCE_W=2, HOLDOFF=4): btns[0] high 20 cycles → pending[0] at edge 7, grant=4'b0001 for exactly 1 cycle, leds 0→1, no second increment.
- Glitch: btns[1] high for 3 cycles, then low → pending stays 0, leds unchanged.
- Contention: leds=3, sw=4'hA, all four pending set in the same cycle →
  - grants in order 0,1,2,3, each spaced 6 cycles;
  - leds 4, 3, 0, A.
- Wrap: leds=0, press btns[1] → leds=4'hF. With BTN_CMD_SATURATE_EN: leds stays 0 and grant still pulses.
- Reset mid-op: assert CPU_RESETN=0 during HOLDOFF with pending[2] set → next cycle state IDLE, pending=0, leds=0, busy=0.
